// File: rtl/wash_fault_monitor.sv
// Fault responder for the washer controller: per-phase watchdog, tach-loss detector and imbalance integrator.
// Optional macro WASH_MON_TACH_GRACE_EN doubles the tach limit until the first tach rise of a motor phase.
module wash_fault_monitor #(
    parameter int unsigned FILL_TIMEOUT = 8,
    parameter int unsigned SOAK_TIMEOUT = 12,
    parameter int unsigned TACH_WINDOW  = 4,
    parameter int unsigned IMB_THRESH   = 3,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] state,
    input  logic       tach_pulse,
    input  logic       imbalance_raw,
    output logic       sig_Time_Out,
    output logic       sig_Motor_Failure,
    output logic       sig_Out_Of_Balance,
    output logic [1:0] fault_code,
    output logic [7:0] fault_count
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        TRIPPED
    } mon_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] FILL_LIM = CNT_W'(FILL_TIMEOUT);
    localparam logic [CNT_W-1:0] SOAK_LIM = CNT_W'(SOAK_TIMEOUT);
    localparam logic [CNT_W-1:0] IMB_LIM  = CNT_W'(IMB_THRESH);
    localparam logic [CNT_W:0]   TACH_LIM = (CNT_W+1)'(TACH_WINDOW);

    mon_state_t       mode;
    logic [3:0]       prev_state;
    logic             tach_q;
    logic [CNT_W-1:0] wd, win, imb;
    logic [CNT_W-1:0] wd_n, win_n, imb_n;
    logic [CNT_W:0]   tach_lim;
    logic             entry, tach_rise;
    logic             in_wd, in_motor, in_imb, operating;
    logic             to_hit, mf_hit, ob_hit;

`ifdef WASH_MON_TACH_GRACE_EN
    localparam logic [CNT_W:0] GRACE_LIM = (CNT_W+1)'(2 * TACH_WINDOW);
    logic grace, grace_n;
`endif

    always_comb begin
        entry     = (state != prev_state);
        tach_rise = tach_pulse & ~tach_q;
        in_wd     = (state == 4'd2) || (state == 4'd3);
        in_motor  = (state >= 4'd4) && (state <= 4'd7);
        in_imb    = (state == 4'd4) || (state == 4'd6) || (state == 4'd7);
        operating = (state >= 4'd2) && (state <= 4'd7);

        wd_n = '0;
        if (in_wd)
            wd_n = entry ? CNT_ONE : ((wd == CNT_MAX) ? wd : wd + CNT_ONE);

        win_n = '0;
        if (in_motor) begin
            if (tach_rise)
                win_n = '0;
            else if (entry)
                win_n = CNT_ONE;
            else
                win_n = (win == CNT_MAX) ? win : win + CNT_ONE;
        end

        imb_n = '0;
        if (in_imb) begin
            if (entry)
                imb_n = imbalance_raw ? CNT_ONE : '0;
            else if (imbalance_raw)
                imb_n = (imb == CNT_MAX) ? imb : imb + CNT_ONE;
            else
                imb_n = (imb == '0) ? '0 : imb - CNT_ONE;
        end

`ifdef WASH_MON_TACH_GRACE_EN
        // Grace lasts from phase entry until the first tach rise seen in that phase.
        grace_n  = in_motor & (entry ? ~tach_rise : (grace & ~tach_rise));
        tach_lim = grace_n ? GRACE_LIM : TACH_LIM;
`else
        tach_lim = TACH_LIM;
`endif

        to_hit = ((state == 4'd2) && (wd_n >= FILL_LIM)) ||
                 ((state == 4'd3) && (wd_n >= SOAK_LIM));
        mf_hit = in_motor && ({1'b0, win_n} >= tach_lim);
        ob_hit = in_imb && (imb_n >= IMB_LIM);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode               <= IDLE;
            prev_state         <= '0;
            tach_q             <= 1'b0;
            wd                 <= '0;
            win                <= '0;
            imb                <= '0;
            sig_Time_Out       <= 1'b0;
            sig_Motor_Failure  <= 1'b0;
            sig_Out_Of_Balance <= 1'b0;
            fault_code         <= '0;
            fault_count        <= '0;
`ifdef WASH_MON_TACH_GRACE_EN
            grace              <= 1'b0;
`endif
        end else begin
            prev_state <= state;
            tach_q     <= tach_pulse;
            // A tripped phase freezes everything until the controller changes state.
            if (mode != TRIPPED || entry) begin
                wd  <= wd_n;
                win <= win_n;
                imb <= imb_n;
`ifdef WASH_MON_TACH_GRACE_EN
                grace <= grace_n;
`endif
                if (to_hit || mf_hit || ob_hit) begin
                    mode               <= TRIPPED;
                    sig_Time_Out       <= to_hit;
                    sig_Motor_Failure  <= mf_hit;
                    sig_Out_Of_Balance <= ob_hit;
                    fault_code         <= mf_hit ? 2'd2 : (ob_hit ? 2'd3 : 2'd1);
                    if (fault_count != 8'hFF)
                        fault_count <= fault_count + 8'd1;
                end else begin
                    mode               <= operating ? ARMED : IDLE;
                    sig_Time_Out       <= 1'b0;
                    sig_Motor_Failure  <= 1'b0;
                    sig_Out_Of_Balance <= 1'b0;
                    fault_code         <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wash_fault_monitor.sv
// Bench for wash_fault_monitor: two instances (default and IMB_THRESH=4) against a phase-history model.
module tb_wash_fault_monitor;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] state = '0;
    logic       tach_pulse = 1'b0;
    logic       imbalance_raw = 1'b0;

    logic       a_to, a_mf, a_ob, b_to, b_mf, b_ob;
    logic [1:0] a_code, b_code;
    logic [7:0] a_cnt, b_cnt;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

`ifdef WASH_MON_TACH_GRACE_EN
    localparam int TRIP_LEN = 8;
`else
    localparam int TRIP_LEN = 4;
`endif

    always #5 clock = ~clock;

    wash_fault_monitor dut (
        .clock(clock), .reset(reset), .state(state), .tach_pulse(tach_pulse),
        .imbalance_raw(imbalance_raw), .sig_Time_Out(a_to), .sig_Motor_Failure(a_mf),
        .sig_Out_Of_Balance(a_ob), .fault_code(a_code), .fault_count(a_cnt)
    );

    wash_fault_monitor #(.IMB_THRESH(4)) dut4 (
        .clock(clock), .reset(reset), .state(state), .tach_pulse(tach_pulse),
        .imbalance_raw(imbalance_raw), .sig_Time_Out(b_to), .sig_Motor_Failure(b_mf),
        .sig_Out_Of_Balance(b_ob), .fault_code(b_code), .fault_count(b_cnt)
    );

    // Model: each phase is described by edges since entry, edges since last tach rise
    // and the running imbalance level; index 0 is the default build, 1 has threshold 4.
    int last_s, last_t;
    int thr[2] = '{3, 4};
    int plen[2], srise[2], ilev[2], trips[2];
    bit rose[2], tripped[2], e_to[2], e_mf[2], e_ob[2];
    int e_code[2];

    task automatic model_reset();
        last_s = 0;
        last_t = 0;
        for (int m = 0; m < 2; m++) begin
            plen[m] = 0; srise[m] = 0; ilev[m] = 0; trips[m] = 0;
            rose[m] = 0; tripped[m] = 0; e_to[m] = 0; e_mf[m] = 0; e_ob[m] = 0; e_code[m] = 0;
        end
    endtask

    task automatic model_edge(input int s, input int t, input int i);
        bit entry, rise;
        int lim;
        entry = (s != last_s);
        rise  = (t == 1) && (last_t == 0);
        for (int m = 0; m < 2; m++) begin
            if (!tripped[m] || entry) begin
                if (entry) begin
                    plen[m] = 1; ilev[m] = i; srise[m] = rise ? 0 : 1; rose[m] = rise;
                end else begin
                    plen[m]++;
                    ilev[m] = (i != 0) ? ilev[m] + 1 : ((ilev[m] > 0) ? ilev[m] - 1 : 0);
                    srise[m] = rise ? 0 : srise[m] + 1;
                    rose[m] = rose[m] | rise;
                end
                lim = 4;
`ifdef WASH_MON_TACH_GRACE_EN
                if (!rose[m]) lim = 8;
`endif
                e_to[m] = (s == 2 && plen[m] >= 8) || (s == 3 && plen[m] >= 12);
                e_mf[m] = (s >= 4 && s <= 7) && (srise[m] >= lim);
                e_ob[m] = (s == 4 || s == 6 || s == 7) && (ilev[m] >= thr[m]);
                tripped[m] = e_to[m] | e_mf[m] | e_ob[m];
                e_code[m] = e_mf[m] ? 2 : (e_ob[m] ? 3 : (e_to[m] ? 1 : 0));
                if (tripped[m]) trips[m]++;
            end
        end
        last_s = s;
        last_t = t;
    endtask

    function automatic logic [12:0] model_vec(input int m);
        int c;
        c = (trips[m] > 255) ? 255 : trips[m];
        return {e_to[m], e_mf[m], e_ob[m], 2'(e_code[m]), 8'(c)};
    endfunction

    always @(negedge clock) begin
        if (check_en) begin
            checks++;
            if ({a_to, a_mf, a_ob, a_code, a_cnt} !== model_vec(0)) begin
                errors++;
                $display("FAIL model_dut t=%0t got to/mf/ob/code/cnt=%b expected %b", $time,
                         {a_to, a_mf, a_ob, a_code, a_cnt}, model_vec(0));
            end
            checks++;
            if ({b_to, b_mf, b_ob, b_code, b_cnt} !== model_vec(1)) begin
                errors++;
                $display("FAIL model_dut4 t=%0t got to/mf/ob/code/cnt=%b expected %b", $time,
                         {b_to, b_mf, b_ob, b_code, b_cnt}, model_vec(1));
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int s, input int t, input int i);
        state = 4'(s);
        tach_pulse = t[0];
        imbalance_raw = i[0];
        @(posedge clock);
        #1;
        model_edge(s, t, i);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        check_en = 1'b0;
        pulse_reset();
        check_en = 1'b1;
        lit("reset_outputs", int'({a_to, a_mf, a_ob, a_code, a_cnt}), 0);

        // Fill watchdog: trips on the 8th consecutive edge.
        for (int k = 0; k < 7; k++) cyc(2, 0, 0);
        lit("fill_edge7_to", int'(a_to), 0);
        cyc(2, 0, 0);
        lit("fill_edge8_to", int'(a_to), 1);
        lit("fill_edge8_code", int'(a_code), 1);
        lit("fill_edge8_count", int'(a_cnt), 1);
        cyc(8, 0, 0);
        lit("fault_state_flags", int'({a_to, a_mf, a_ob, a_code}), 0);
        lit("fault_state_count", int'(a_cnt), 1);

        // Wash with a tach rise every third cycle, then tach stops.
        for (int k = 0; k < 40; k++) cyc(4, (k % 3 == 0) ? 1 : 0, 0);
        lit("wash_running_flags", int'({a_to, a_mf, a_ob}), 0);
        for (int k = 0; k < 3; k++) cyc(4, 0, 0);
        lit("wash_stop3_mf", int'(a_mf), 0);
        cyc(4, 0, 0);
        lit("wash_stop4_mf", int'(a_mf), 1);
        lit("wash_stop4_code", int'(a_code), 2);
        lit("wash_stop4_count", int'(a_cnt), 2);

        // Spin imbalance 1,1,0,1,1 -> level 1,2,1,2,3.
        cyc(6, 1, 1); cyc(6, 0, 1); cyc(6, 1, 0); cyc(6, 0, 1);
        lit("spin_edge4_ob", int'(a_ob), 0);
        cyc(6, 1, 1);
        lit("spin_edge5_ob", int'(a_ob), 1);
        lit("spin_edge5_code", int'(a_code), 3);
        lit("spin_edge5_mf", int'(a_mf), 0);

        // Dry with tach stopped and constant imbalance.
        for (int k = 0; k < 3; k++) cyc(7, 0, 1);
        lit("dry_edge3_ob_thr3", int'(a_ob), 1);
        lit("dry_edge3_code_thr3", int'(a_code), 3);
        lit("dry_edge3_flags_thr4", int'({b_to, b_mf, b_ob}), 0);
        cyc(7, 0, 1);
`ifndef WASH_MON_TACH_GRACE_EN
        lit("dry_edge4_flags_thr4", int'({b_mf, b_ob}), 3);
        lit("dry_edge4_code_thr4", int'(b_code), 2);
        lit("dry_edge4_count_thr4", int'(b_cnt), 3);
`endif

        // Reset mid-soak, then soak restarts from the first edge.
        for (int k = 0; k < 5; k++) cyc(3, 0, 0);
        state = 4'd3;
        pulse_reset();
        lit("midsoak_reset_outputs", int'({a_to, a_mf, a_ob, a_code, a_cnt}), 0);
        for (int k = 0; k < 11; k++) cyc(3, 0, 0);
        lit("soak_edge11_to", int'(a_to), 0);
        cyc(3, 0, 0);
        lit("soak_edge12_to", int'(a_to), 1);
        lit("soak_edge12_count", int'(a_cnt), 1);

        // Alternate WASH/RINSE with no tach to force 256 more trips.
        for (int n = 0; n < 256; n++)
            for (int k = 0; k < TRIP_LEN; k++) cyc((n % 2 == 0) ? 4 : 5, 0, 0);
        lit("count_saturated", int'(a_cnt), 255);
        lit("count_saturated_thr4", int'(b_cnt), 255);

        for (int k = 0; k < 6; k++) cyc(12, k % 2, 1);
        lit("state12_idle_flags", int'({a_to, a_mf, a_ob, a_code}), 0);
        lit("state12_count", int'(a_cnt), 255);

        @(posedge clock);
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
